// File: rtl/bridge_controller.sv
// Drawbridge sequencer: closes the road, waits for an empty deck, raises the
// bridge for a boat, lowers it and reopens the road once it is confirmed down.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SAFE       | post-reset hold, road closed, decides reopen vs. lower
// ROAD_OPEN  | green light, gate up, accumulating minimum road time
// CLOSING    | yellow light, warning cars before the gate drops
// WAIT_CLEAR | red, gate down, waiting for the deck to empty
// RAISING    | motor up until the raised limit switch trips
// BOAT_PASS  | bridge up, boat signal green
// LOWERING   | motor down until the lowered limit switch trips
// FAULT      | latched error, everything safe, exit only via reset
module bridge_controller #(
    parameter int YELLOW_CYCLES   = 8,
    parameter int MIN_ROAD_CYCLES = 32,
    parameter int MIN_BOAT_CYCLES = 16,
    parameter int MOTOR_TIMEOUT   = 64,
    parameter int CNT_W           = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ExistCar,
    input  logic       BoatReq,
    input  logic       BoatClear,
    input  logic       BridgeUp,
    input  logic       BridgeDown,
    output logic [1:0] CarLight,
    output logic       GateClosed,
    output logic       MotorUp,
    output logic       MotorDown,
    output logic       BoatGo,
    output logic       Fault,
    output logic [2:0] State
);

    localparam logic [2:0] SAFE       = 3'd0;
    localparam logic [2:0] ROAD_OPEN  = 3'd1;
    localparam logic [2:0] CLOSING    = 3'd2;
    localparam logic [2:0] WAIT_CLEAR = 3'd3;
    localparam logic [2:0] RAISING    = 3'd4;
    localparam logic [2:0] BOAT_PASS  = 3'd5;
    localparam logic [2:0] LOWERING   = 3'd6;
    localparam logic [2:0] FAULT      = 3'd7;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    localparam logic [CNT_W-1:0] T_YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_ROAD_MIN    = CNT_W'(MIN_ROAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_BOAT_MIN    = CNT_W'(MIN_BOAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_MOTOR_LAST  = CNT_W'(MOTOR_TIMEOUT - 1);

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] timer_q,   timer_d;
    logic             pending_q, pending_d;
    logic             sensor_conflict;
    logic             motor_timeout;

    assign sensor_conflict = BridgeUp & BridgeDown;
    assign motor_timeout   = (timer_q == T_MOTOR_LAST);

    always_comb begin
        state_d = state_q;
        if (sensor_conflict && state_q != SAFE && state_q != FAULT) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                SAFE:       state_d = BridgeDown ? ROAD_OPEN : LOWERING;
                ROAD_OPEN: begin
                    if ((pending_q || BoatReq) && timer_q >= T_ROAD_MIN)
                        state_d = CLOSING;
                end
                CLOSING: begin
                    if (timer_q == T_YELLOW_LAST)
                        state_d = WAIT_CLEAR;
                end
                WAIT_CLEAR: begin
                    if (!ExistCar)
                        state_d = RAISING;
                end
                // Reaching the limit switch wins over a coincident timeout.
                RAISING: begin
                    if (BridgeUp)
                        state_d = BOAT_PASS;
                    else if (motor_timeout)
                        state_d = FAULT;
                end
                BOAT_PASS: begin
                    if (BoatClear && timer_q >= T_BOAT_MIN)
                        state_d = LOWERING;
                end
                LOWERING: begin
                    if (BridgeDown)
                        state_d = ROAD_OPEN;
                    else if (motor_timeout)
                        state_d = FAULT;
                end
                default:    state_d = FAULT;
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q == '1)
            timer_d = timer_q;
        else
            timer_d = timer_q + CNT_W'(1);
    end

    // Requests seen while the boat is already being served are dropped.
    always_comb begin
        pending_d = pending_q;
        if (state_d == BOAT_PASS && state_q != BOAT_PASS)
            pending_d = 1'b0;
        else if (BoatReq && state_q != BOAT_PASS)
            pending_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= SAFE;
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        CarLight   = LIGHT_RED;
        GateClosed = 1'b1;
        MotorUp    = 1'b0;
        MotorDown  = 1'b0;
        BoatGo     = 1'b0;
        Fault      = 1'b0;
        case (state_q)
            ROAD_OPEN: begin
                CarLight   = LIGHT_GREEN;
                GateClosed = 1'b0;
            end
            CLOSING: begin
                CarLight   = LIGHT_YELLOW;
                GateClosed = 1'b0;
            end
            RAISING:   MotorUp   = 1'b1;
            BOAT_PASS: BoatGo    = 1'b1;
            LOWERING:  MotorDown = 1'b1;
            FAULT:     Fault     = 1'b1;
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_bridge_controller.sv
// Self-checking bench for bridge_controller: a vector table walks the main
// sequence, hand-written sequences cover async reset and edge-of-timeout cases.
module tb_bridge_controller;

    localparam logic [2:0] S_SAFE = 3'd0, S_ROAD = 3'd1, S_CLOSE = 3'd2,
                           S_WAIT = 3'd3, S_RAISE = 3'd4, S_BOAT = 3'd5,
                           S_LOWER = 3'd6, S_FAULT = 3'd7;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ExistCar = 1'b0, BoatReq = 1'b0, BoatClear = 1'b0;
    logic       BridgeUp = 1'b0, BridgeDown = 1'b1;
    logic [1:0] CarLight;
    logic       GateClosed, MotorUp, MotorDown, BoatGo, Fault;
    logic [2:0] State;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       ec;
        logic       br;
        logic       bc;
        logic       bu;
        logic       bd;
        int         n;
        logic [2:0] exp;
    } vec_t;

    logic [2:0] exp_q[$];
    string      name_q[$];

    bridge_controller dut (
        .Clk(Clk), .Reset(Reset), .ExistCar(ExistCar), .BoatReq(BoatReq),
        .BoatClear(BoatClear), .BridgeUp(BridgeUp), .BridgeDown(BridgeDown),
        .CarLight(CarLight), .GateClosed(GateClosed), .MotorUp(MotorUp),
        .MotorDown(MotorDown), .BoatGo(BoatGo), .Fault(Fault), .State(State)
    );

    always #5 Clk = ~Clk;

    // {CarLight, GateClosed, MotorUp, MotorDown, BoatGo, Fault}
    function automatic logic [6:0] exp_out(input logic [2:0] s);
        case (s)
            S_ROAD:  return 7'b00_0_0_0_0_0;
            S_CLOSE: return 7'b01_0_0_0_0_0;
            S_RAISE: return 7'b10_1_1_0_0_0;
            S_BOAT:  return 7'b10_1_0_0_1_0;
            S_LOWER: return 7'b10_1_0_1_0_0;
            S_FAULT: return 7'b10_1_0_0_0_1;
            default: return 7'b10_1_0_0_0_0;
        endcase
    endfunction

    task automatic check_now(input logic [2:0] exp, input string nm);
        logic [6:0] act_o;
        act_o = {CarLight, GateClosed, MotorUp, MotorDown, BoatGo, Fault};
        total++;
        if (State !== exp) begin
            bad++;
            $display("FAIL %s state: got %0d want %0d", nm, State, exp);
        end
        total++;
        if (act_o !== exp_out(exp)) begin
            bad++;
            $display("FAIL %s outputs: got %b want %b", nm, act_o, exp_out(exp));
        end
    endtask

    // Drive at a negedge, run n rising edges, compare at the following negedge.
    task automatic step(input vec_t v, input string nm);
        logic [2:0] e;
        string      s;
        Reset = v.rst; ExistCar = v.ec; BoatReq = v.br; BoatClear = v.bc;
        BridgeUp = v.bu; BridgeDown = v.bd;
        exp_q.push_back(v.exp);
        name_q.push_back(nm);
        repeat (v.n) @(posedge Clk);
        @(negedge Clk);
        e = exp_q.pop_front();
        s = name_q.pop_front();
        check_now(e, s);
    endtask

    function automatic vec_t mk(input logic rst, ec, br, bc, bu, bd,
                                input int n, input logic [2:0] exp);
        vec_t v;
        v.rst = rst; v.ec = ec; v.br = br; v.bc = bc; v.bu = bu; v.bd = bd;
        v.n = n; v.exp = exp;
        return v;
    endfunction

    task automatic to_raising();
        step(mk(0,0,0,0,0,1, 1, S_SAFE),  "pre_reset");
        step(mk(1,0,0,0,0,1, 1, S_ROAD),  "pre_road");
        step(mk(1,0,1,0,0,1,32, S_CLOSE), "pre_close");
        step(mk(1,0,0,0,0,1, 8, S_WAIT),  "pre_wait");
        step(mk(1,0,0,0,0,1, 1, S_RAISE), "pre_raise");
    endtask

    // Structural invariants sampled every cycle.
    always @(negedge Clk) begin
        total++;
        if (MotorUp && MotorDown) begin
            bad++;
            $display("FAIL inv_motors: up=%b down=%b want not both", MotorUp, MotorDown);
        end
        total++;
        if (BoatGo && CarLight != 2'b10) begin
            bad++;
            $display("FAIL inv_boatgo_red: light=%b want 10", CarLight);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time=%0t want run complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        tbl.push_back(mk(0,0,0,0,0,1, 2, S_SAFE));   // 0 in reset
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_ROAD));   // 1 SAFE -> ROAD_OPEN
        tbl.push_back(mk(1,0,0,0,0,1, 5, S_ROAD));   // 2 timer 5
        tbl.push_back(mk(1,0,1,0,0,1, 1, S_ROAD));   // 3 request pulse
        tbl.push_back(mk(1,0,0,0,0,1,24, S_ROAD));   // 4 timer 30
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_ROAD));   // 5 timer 31
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_CLOSE));  // 6 pending served
        tbl.push_back(mk(1,0,0,0,0,1, 7, S_CLOSE));  // 7 still yellow
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_WAIT));   // 8 yellow for 8
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_RAISE));  // 9 deck empty
        tbl.push_back(mk(1,0,0,0,0,0,10, S_RAISE));  // 10
        tbl.push_back(mk(1,0,0,0,1,0, 1, S_BOAT));   // 11 raised
        tbl.push_back(mk(1,0,1,0,1,0, 3, S_BOAT));   // 12 req not latched
        tbl.push_back(mk(1,0,0,1,1,0,12, S_BOAT));   // 13 clear early, hold
        tbl.push_back(mk(1,0,0,1,0,0, 1, S_LOWER));  // 14 min boat time met
        tbl.push_back(mk(1,0,0,0,0,0, 9, S_LOWER));  // 15
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_ROAD));   // 16 lowered
        tbl.push_back(mk(1,0,0,0,0,1,40, S_ROAD));   // 17 no stale pending
        tbl.push_back(mk(1,0,1,0,0,1, 1, S_CLOSE));  // 18 live request
        tbl.push_back(mk(1,0,0,0,0,1, 8, S_WAIT));   // 19
        tbl.push_back(mk(1,1,0,0,0,1,20, S_WAIT));   // 20 cars on deck
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_RAISE));  // 21 cars gone
        tbl.push_back(mk(1,0,0,0,0,0,63, S_RAISE));  // 22 timer 63
        tbl.push_back(mk(1,0,0,0,0,0, 1, S_FAULT));  // 23 timeout
        tbl.push_back(mk(1,0,0,0,1,0,10, S_FAULT));  // 24 absorbing
        tbl.push_back(mk(0,0,0,0,0,0, 1, S_SAFE));   // 25 reset
        tbl.push_back(mk(1,0,0,0,0,0, 1, S_LOWER));  // 26 not down -> lower
        tbl.push_back(mk(1,0,0,0,0,1, 1, S_ROAD));   // 27
        tbl.push_back(mk(1,0,0,0,1,1, 1, S_FAULT));  // 28 sensor conflict

        @(negedge Clk);
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Async reset mid-raise stops the motor without waiting for a clock.
        to_raising();
        step(mk(1,0,0,0,0,0, 5, S_RAISE), "mid_raise");
        #2;
        Reset = 1'b0;
        #1;
        total++;
        if (MotorUp !== 1'b0) begin
            bad++;
            $display("FAIL async_motor_off: got %b want 0", MotorUp);
        end
        check_now(S_SAFE, "async_state");
        @(negedge Clk);
        step(mk(1,0,0,0,0,0, 1, S_LOWER), "reset_lower");

        // Limit switch in the timeout cycle wins; request during LOWERING is kept.
        to_raising();
        step(mk(1,0,0,0,0,0,63, S_RAISE), "raise_t63");
        step(mk(1,0,0,0,1,0, 1, S_BOAT),  "raise_beats_to");
        step(mk(1,0,0,1,1,0,16, S_LOWER), "boat_min");
        step(mk(1,0,1,0,0,0, 1, S_LOWER), "lower_req");
        step(mk(1,0,0,0,0,0,62, S_LOWER), "lower_t63");
        step(mk(1,0,0,0,0,1, 1, S_ROAD),  "lower_beats_to");
        step(mk(1,0,0,0,0,1,31, S_ROAD),  "latched_wait");
        step(mk(1,0,0,0,0,1, 1, S_CLOSE), "latched_served");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bridge_controller.md
Name: bridge_controller

Overview:
Drawbridge sequencer. It consumes the car-occupancy flag (ExistCar) produced by the bridge car counter, plus boat and bridge-position sensors. It drives the road traffic light, road gate, bridge motor and boat signal. The road is closed and the bridge is raised only after the deck is empty of cars, and the road is reopened only after the bridge is confirmed down.

Parameters:
YELLOW_CYCLES, 8, cycles the road light stays yellow before turning red
MIN_ROAD_CYCLES, 32, minimum cycles the road stays open before a boat request is served
MIN_BOAT_CYCLES, 16, minimum cycles BoatGo stays asserted
MOTOR_TIMEOUT, 64, maximum cycles allowed for a raise or lower before fault
CNT_W, 8, width of the state timer; must hold the largest parameter

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
ExistCar  input  1  1 = at least one car on the deck (from the car counter)
BoatReq  input  1  boat waiting; level or pulse
BoatClear  input  1  boat has passed the bridge
BridgeUp  input  1  bridge fully-raised limit switch
BridgeDown  input  1  bridge fully-lowered limit switch
CarLight  output  2  00 green, 01 yellow, 10 red
GateClosed  output  1  road barrier down
MotorUp  output  1  raise command
MotorDown  output  1  lower command
BoatGo  output  1  boat signal green
Fault  output  1  latched fault
State  output  3  current state encoding, for debug

Behaviour:
- Moore FSM. All outputs decode from the registered state only; they change in the same cycle the state register changes.
- Timer: CNT_W bits, cleared to 0 on every state transition, otherwise increments each cycle and saturates at all-ones.
- Pending flag: set when BoatReq=1 in any state other than BOAT_PASS; cleared on entry to BOAT_PASS.
- States and encodings:
  - SAFE (0): red, gate closed, motors off.
  - ROAD_OPEN (1): green, gate open.
  - CLOSING (2): yellow, gate open.
  - WAIT_CLEAR (3): red, gate closed.
  - RAISING (4): red, gate closed, MotorUp=1.
  - BOAT_PASS (5): red, gate closed, BoatGo=1.
  - LOWERING (6): red, gate closed, MotorDown=1.
  - FAULT (7): red, gate closed, motors off, Fault=1.
- Reset (async, Reset=0): state=SAFE, timer=0, pending=0. Outputs are CarLight=10, GateClosed=1, MotorUp=0, MotorDown=0, BoatGo=0, Fault=0. Reset asserted mid-raise or mid-lower stops both motors immediately.
- Transitions:
  - SAFE: next cycle -> ROAD_OPEN if BridgeDown=1, else LOWERING.
  - ROAD_OPEN: -> CLOSING when (pending or BoatReq) and timer >= MIN_ROAD_CYCLES-1.
  - CLOSING: -> WAIT_CLEAR when timer = YELLOW_CYCLES-1.
  - WAIT_CLEAR: -> RAISING when ExistCar=0. There is no timeout; it waits indefinitely for cars to leave.
  - RAISING: -> BOAT_PASS when BridgeUp=1; -> FAULT when timer = MOTOR_TIMEOUT-1 with BridgeUp=0.
  - BOAT_PASS: -> LOWERING when BoatClear=1 and timer >= MIN_BOAT_CYCLES-1.
  - LOWERING: -> ROAD_OPEN when BridgeDown=1; -> FAULT on timeout, same rule as RAISING.
  - FAULT: absorbing; exit only via Reset.
- Sensor conflict: BridgeUp=1 and BridgeDown=1 in the same cycle, in any state except SAFE and FAULT, -> FAULT next cycle. This has priority over all other transitions.
- ExistCar rising again during RAISING or BOAT_PASS is ignored because the gate is already closed.
- Simultaneous events: in RAISING, BridgeUp=1 in the timeout cycle -> BOAT_PASS, not FAULT (success beats timeout); the same rule applies to LOWERING.
- A boat request arriving while in BOAT_PASS is not latched. A request arriving during LOWERING is latched and served after the minimum road time.
- Invariants (the verifier asserts these):
  - MotorUp and MotorDown are never 1 together.
  - GateClosed=0 implies BridgeDown was 1 on entry to ROAD_OPEN.
  - BoatGo=1 implies CarLight=10.

Test Plan:
- Reset release with BridgeDown=1 -> SAFE for 1 cycle, then ROAD_OPEN, CarLight=00, GateClosed=0.
- BoatReq pulse at timer=5 in ROAD_OPEN, ExistCar=0 -> pending held. CLOSING entered at timer=31, yellow for 8 cycles, then WAIT_CLEAR, then RAISING one cycle later.
- Same as above but ExistCar=1 for 20 cycles -> remains in WAIT_CLEAR with MotorUp=0 throughout; RAISING in the cycle after ExistCar falls.
- RAISING with BridgeUp held 0 -> FAULT after exactly 64 cycles, motors 0, Fault=1; FAULT persists until Reset=0.
- BOAT_PASS with BoatClear=1 at timer=3 -> stays until timer=15, then LOWERING. BridgeDown=1 after 10 cycles -> ROAD_OPEN, green.
- Reset asserted mid-RAISING, then released with BridgeDown=0 -> MotorUp drops at once, SAFE, then LOWERING. BridgeUp and BridgeDown both 1 in ROAD_OPEN -> FAULT next cycle.
